// File: rtl/converter.sv
// Binary32 adder with round-to-nearest-even, flush-to-zero on denormals and a registered result.
// Define FP_STATUS_FLAGS_EN to add the registered overflow/underflow/exception outputs.
module converter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] result
`ifdef FP_STATUS_FLAGS_EN
    ,
    output logic            overflow,
    output logic            underflow,
    output logic            exception
`endif
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Unpacked operands
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sa = A[31];
    assign ea = A[30:23];
    assign fa = A[22:0];
    assign sb = B[31];
    assign eb = B[30:23];
    assign fb = B[22:0];

    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);

    // Larger-magnitude operand becomes X
    logic        swap;
    logic        sx, sy;
    logic [7:0]  ex, ey;
    logic [23:0] mx, my;
    logic        eff_sub;

    assign swap    = {eb, fb} > {ea, fa};
    assign sx      = swap ? sb : sa;
    assign sy      = swap ? sa : sb;
    assign ex      = swap ? eb : ea;
    assign ey      = swap ? ea : eb;
    assign mx      = swap ? {1'b1, fb} : {1'b1, fa};
    assign my      = swap ? {1'b1, fa} : {1'b1, fb};
    assign eff_sub = sx ^ sy;

    // Alignment of Y, keeping guard/round/sticky
    logic [7:0]  d;
    logic [49:0] y_wide;
    logic [23:0] y_al;
    logic        y_g, y_r, y_s;

    assign d = ex - ey;

    always_comb begin
        y_wide = {my, 26'd0} >> d;
        if (d >= 8'd26) begin
            y_al = 24'd0;
            y_g  = 1'b0;
            y_r  = 1'b0;
            y_s  = (my != 24'd0);
        end else begin
            y_al = y_wide[49:26];
            y_g  = y_wide[25];
            y_r  = y_wide[24];
            y_s  = |y_wide[23:0];
        end
    end

    // Significand add/subtract on {mant, g, r, s}
    logic [26:0] op_x, op_y;
    logic [27:0] sum28;
    logic [26:0] diff27;

    assign op_x   = {mx, 3'b000};
    assign op_y   = {y_al, y_g, y_r, y_s};
    assign sum28  = {1'b0, op_x} + {1'b0, op_y};
    assign diff27 = op_x - op_y;

    // Leading-zero count of the difference; the highest set bit wins
    logic [4:0] lzc;

    always_comb begin
        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (diff27[i]) begin
                lzc = 5'(26 - i);
            end
        end
    end

    // Normalisation
    logic        [26:0] norm;
    logic signed [9:0]  e_norm;

    always_comb begin
        norm   = 27'd0;
        e_norm = 10'sd0;
        if (!eff_sub) begin
            if (sum28[27]) begin
                norm   = {sum28[27:2], sum28[1] | sum28[0]};
                e_norm = $signed({2'b00, ex} + 10'd1);
            end else begin
                norm   = sum28[26:0];
                e_norm = $signed({2'b00, ex});
            end
        end else begin
            norm   = diff27 << lzc;
            e_norm = $signed({2'b00, ex} - {5'd0, lzc});
        end
    end

    // Round to nearest, ties to even
    logic               rnd_up;
    logic        [24:0] mant_r;
    logic        [22:0] frac_out;
    logic signed [9:0]  e_round;

    assign rnd_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mant_r   = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    assign frac_out = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    assign e_round  = mant_r[24] ? (e_norm + 10'sd1) : e_norm;

    // Result selection: specials first, then the arithmetic path
    logic        cancel;
    logic        finite_path;
    logic [31:0] result_next;
    logic [31:0] result_reg;

    assign cancel      = eff_sub && (diff27 == 27'd0);
    assign finite_path = (ea != 8'hFF) && (eb != 8'hFF) && !zero_a && !zero_b;

    always_comb begin
        result_next = 32'd0;
        if (nan_a || nan_b) begin
            result_next = QNAN;
        end else if (inf_a && inf_b) begin
            result_next = (sa != sb) ? QNAN : A;
        end else if (inf_a) begin
            result_next = A;
        end else if (inf_b) begin
            result_next = B;
        end else if (zero_a && zero_b) begin
            result_next = {sa & sb, 31'd0};
        end else if (zero_a) begin
            result_next = {sb, eb, fb};
        end else if (zero_b) begin
            result_next = {sa, ea, fa};
        end else if (cancel) begin
            result_next = 32'd0;
        end else if (e_norm <= 10'sd0) begin
            result_next = {sx, 31'd0};
        end else if (e_round >= 10'sd255) begin
            result_next = {sx, 8'hFF, 23'd0};
        end else begin
            result_next = {sx, e_round[7:0], frac_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= 32'd0;
        end else begin
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

`ifdef FP_STATUS_FLAGS_EN
    logic overflow_next, underflow_next, exception_next;
    logic overflow_reg, underflow_reg, exception_reg;

    assign exception_next = nan_a || nan_b || (inf_a && inf_b && (sa != sb));
    assign overflow_next  = finite_path && !cancel && (e_norm > 10'sd0) && (e_round >= 10'sd255);
    assign underflow_next = finite_path && !cancel && (e_norm <= 10'sd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            exception_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            exception_reg <= exception_next;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign exception = exception_reg;
`endif

endmodule

// File: tb/tb_converter.sv
// Scoreboard bench for the binary32 adder: the driver queues expected sums,
// a monitor pops and compares one edge after each operation is captured.
module tb_converter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic [31:0] result;
`ifdef FP_STATUS_FLAGS_EN
    logic        overflow, underflow, exception;
`endif

    converter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .result    (result)
`ifdef FP_STATUS_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        exc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic ovf, input logic unf, input logic exc, input string name);
        @(negedge clk);
        A = a;
        B = b;
        exp_q.push_back('{a, b, res, ovf, unf, exc, name});
    endtask

    // Monitor: one queued entry per captured operation, checked just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("op %-10s %08h + %08h -> %08h (expect %08h)", e.name, e.a, e.b, result, e.res);
                check32(e.name, result, e.res);
`ifdef FP_STATUS_FLAGS_EN
                check1({e.name, ".ovf"}, overflow, e.ovf);
                check1({e.name, ".unf"}, underflow, e.unf);
                check1({e.name, ".exc"}, exception, e.exc);
`endif
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check32("rst_init", result, 32'h0000_0000);
`ifdef FP_STATUS_FLAGS_EN
        check1("rst_init.ovf", overflow, 1'b0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back to back
        apply(32'h404CCCCC, 32'h40866666, 32'h40ECCCCC, 0, 0, 0, "add_3p2");
        apply(32'hBF000000, 32'h40CCCCCC, 32'h40BCCCCC, 0, 0, 0, "sub_6p4");
        apply(32'h3FC00000, 32'h40100000, 32'h40700000, 0, 0, 0, "add_1p5");
        apply(32'h3F800000, 32'h33800000, 32'h3F800000, 0, 0, 0, "tie_even");
        apply(32'h3F800001, 32'h33800000, 32'h3F800002, 0, 0, 0, "tie_odd");
        apply(32'h40490FDB, 32'hC0490FDB, 32'h00000000, 0, 0, 0, "cancel");
        apply(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0, 0, "overflow");
        apply(32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 0, 1, "inf_minf");
        apply(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0, 1, "nan_in");
        apply(32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0, "mz_mz");
        apply(32'h00000000, 32'h80000000, 32'h00000000, 0, 0, 0, "pz_mz");
        apply(32'h7F800000, 32'h3F800000, 32'h7F800000, 0, 0, 0, "inf_fin");
        apply(32'hFF800000, 32'hFF800000, 32'hFF800000, 0, 0, 0, "minf_minf");
        apply(32'h3F800000, 32'h00000001, 32'h3F800000, 0, 0, 0, "denorm_ftz");
        apply(32'h00800001, 32'h80800000, 32'h00000000, 0, 1, 0, "underflow");
        apply(32'h3F800001, 32'hBF800000, 32'h34000000, 0, 0, 0, "norm_left");
        apply(32'h3F800000, 32'hB3000000, 32'h3F800000, 0, 0, 0, "sub_tie");
        apply(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 0, "one_one");
        apply(32'hFF800000, 32'h7FC00000, 32'h7FC00000, 0, 0, 1, "minf_nan");
        apply(32'hC0000000, 32'h3F800000, 32'hBF800000, 0, 0, 0, "neg_res");

        // Reset between edges clears the result immediately and drops the in-flight sum
        apply(32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 0, "pre_rst");
        @(posedge clk);
        #2;
        A = 32'h3F800000;
        B = 32'h3F800000;
        rst_n = 1'b0;
        #1;
        check32("rst_async", result, 32'h0000_0000);
        @(posedge clk);
        #1;
        check32("rst_hold", result, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        A = 32'h3F800000;
        B = 32'h40000000;
        exp_q.push_back('{32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, "post_rst"});

        repeat (3) @(negedge clk);
        check32("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
